// File: rtl/change_dispenser_pkg.sv
// ============================================================================
// change_pkg : shared states, coin identifiers and default parameter values
// Rev 1.0
// ============================================================================
`default_nettype none

package change_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GIVE = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CIRC = 2'd1,
    TRI  = 2'd2,
    PENT = 2'd3
  } coin_t;

  localparam int DEF_VALUE_W   = 4;
  localparam int DEF_COUNT_W   = 2;
  localparam int DEF_MAX_COINS = 2;
  localparam int DEF_PENT_VAL  = 5;
  localparam int DEF_TRI_VAL   = 3;
  localparam int DEF_CIRC_VAL  = 1;
  localparam int DEF_INIT_CNT  = 3;

endpackage

`default_nettype wire

// File: rtl/change_dispenser_coin_picker.sv
// ============================================================================
// coin_picker : greedy choice of the largest in-stock coin not exceeding remaining
// Rev 1.0
// ============================================================================
`default_nettype none

module coin_picker import change_pkg::*; #(
  parameter int VALUE_W = DEF_VALUE_W,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic [VALUE_W-1:0] remaining,
  input  logic [COUNT_W-1:0] pent_cnt,
  input  logic [COUNT_W-1:0] tri_cnt,
  input  logic [COUNT_W-1:0] circ_cnt,
  input  logic [VALUE_W-1:0] pent_val,
  input  logic [VALUE_W-1:0] tri_val,
  input  logic [VALUE_W-1:0] circ_val,
  output coin_t              choice,
  output logic [VALUE_W-1:0] value,
  output logic               valid
);

  always_comb begin
    choice = NONE;
    value  = '0;
    valid  = 1'b0;
    if (pent_cnt != '0 && pent_val <= remaining) begin
      choice = PENT;
      value  = pent_val;
      valid  = 1'b1;
    end else if (tri_cnt != '0 && tri_val <= remaining) begin
      choice = TRI;
      value  = tri_val;
      valid  = 1'b1;
    end else if (circ_cnt != '0 && circ_val <= remaining) begin
      choice = CIRC;
      value  = circ_val;
      valid  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// change_dispenser : transaction FSM and coin inventory, one coin per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module change_dispenser import change_pkg::*; #(
  parameter int VALUE_W   = DEF_VALUE_W,
  parameter int COUNT_W   = DEF_COUNT_W,
  parameter int MAX_COINS = DEF_MAX_COINS,
  parameter int PENT_VAL  = DEF_PENT_VAL,
  parameter int TRI_VAL   = DEF_TRI_VAL,
  parameter int CIRC_VAL  = DEF_CIRC_VAL,
  parameter int INIT_CNT  = DEF_INIT_CNT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [VALUE_W-1:0] paid,
  input  logic [VALUE_W-1:0] cost,
  input  logic               restock,
  input  logic [COUNT_W-1:0] restock_pent,
  input  logic [COUNT_W-1:0] restock_tri,
  input  logic [COUNT_W-1:0] restock_circ,
  output logic               busy,
  output logic               coin_valid,
  output logic [VALUE_W-1:0] coin,
  output logic               done,
  output logic               exact_amount,
  output logic               not_enough_change,
  output logic               cough_up_more,
  output logic [VALUE_W-1:0] remaining,
  output logic [COUNT_W-1:0] pent_left,
  output logic [COUNT_W-1:0] tri_left,
  output logic [COUNT_W-1:0] circ_left
);

  localparam int                 CNT_W     = $clog2(MAX_COINS + 1);
  localparam logic [CNT_W-1:0]   LAST_COIN = CNT_W'(MAX_COINS - 1);
  localparam logic [VALUE_W-1:0] PENT_V    = VALUE_W'(PENT_VAL);
  localparam logic [VALUE_W-1:0] TRI_V     = VALUE_W'(TRI_VAL);
  localparam logic [VALUE_W-1:0] CIRC_V    = VALUE_W'(CIRC_VAL);
  localparam logic [COUNT_W-1:0] INIT_C    = COUNT_W'(INIT_CNT);

  state_t             state;
  logic [CNT_W-1:0]   coin_cnt;
  coin_t              pick;
  logic [VALUE_W-1:0] pick_value;
  logic               pick_valid;
  logic [VALUE_W-1:0] rem_next;

  coin_picker #(
    .VALUE_W (VALUE_W),
    .COUNT_W (COUNT_W)
  ) u_picker (
    .remaining (remaining),
    .pent_cnt  (pent_left),
    .tri_cnt   (tri_left),
    .circ_cnt  (circ_left),
    .pent_val  (PENT_V),
    .tri_val   (TRI_V),
    .circ_val  (CIRC_V),
    .choice    (pick),
    .value     (pick_value),
    .valid     (pick_valid)
  );

  assign rem_next   = remaining - pick_value;
  assign busy       = (state != IDLE);
  assign coin_valid = (state == GIVE) && pick_valid;
  assign coin       = coin_valid ? pick_value : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      pent_left         <= INIT_C;
      tri_left          <= INIT_C;
      circ_left         <= INIT_C;
      remaining         <= '0;
      exact_amount      <= 1'b0;
      not_enough_change <= 1'b0;
      cough_up_more     <= 1'b0;
      coin_cnt          <= '0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Restock takes priority over a simultaneous start.
          if (restock) begin
            pent_left <= restock_pent;
            tri_left  <= restock_tri;
            circ_left <= restock_circ;
          end else if (start) begin
            exact_amount      <= 1'b0;
            not_enough_change <= 1'b0;
            cough_up_more     <= 1'b0;
            coin_cnt          <= '0;
            if (paid < cost) begin
              cough_up_more <= 1'b1;
              remaining     <= '0;
              state         <= DONE;
              done          <= 1'b1;
            end else if (paid == cost) begin
              exact_amount <= 1'b1;
              remaining    <= '0;
              state        <= DONE;
              done         <= 1'b1;
            end else begin
              remaining <= paid - cost;
              state     <= GIVE;
            end
          end
        end
        GIVE: begin
          if (pick_valid) begin
            case (pick)
              PENT:    pent_left <= pent_left - COUNT_W'(1);
              TRI:     tri_left  <= tri_left  - COUNT_W'(1);
              CIRC:    circ_left <= circ_left - COUNT_W'(1);
              default: ;
            endcase
            remaining <= rem_next;
            coin_cnt  <= coin_cnt + CNT_W'(1);
            if (rem_next == '0 || coin_cnt == LAST_COIN) begin
              not_enough_change <= (rem_next != '0);
              state             <= DONE;
              done              <= 1'b1;
            end
          end else begin
            not_enough_change <= 1'b1;
            state             <= DONE;
            done              <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// tb_change_dispenser : directed scoreboard bench for change_dispenser
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       reset, start, restock;
  logic [3:0] paid, cost;
  logic [1:0] restock_pent, restock_tri, restock_circ;
  logic       busy, coin_valid, done;
  logic       exact_amount, not_enough_change, cough_up_more;
  logic [3:0] coin, remaining;
  logic [1:0] pent_left, tri_left, circ_left;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cy;
    logic [3:0] val;
  } coin_exp_t;

  typedef struct {
    int         cy;
    logic       ex, nec, cum;
    logic [3:0] rem;
    logic [1:0] p, t, c;
  } done_exp_t;

  coin_exp_t coin_q[$];
  done_exp_t done_q[$];
  coin_exp_t ce;
  done_exp_t de;

  change_dispenser dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .paid              (paid),
    .cost              (cost),
    .restock           (restock),
    .restock_pent      (restock_pent),
    .restock_tri       (restock_tri),
    .restock_circ      (restock_circ),
    .busy              (busy),
    .coin_valid        (coin_valid),
    .coin              (coin),
    .done              (done),
    .exact_amount      (exact_amount),
    .not_enough_change (not_enough_change),
    .cough_up_more     (cough_up_more),
    .remaining         (remaining),
    .pent_left         (pent_left),
    .tri_left          (tri_left),
    .circ_left         (circ_left)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every coin and done seen on the outputs is matched to the scoreboard.
  always @(negedge clock) begin
    if (coin_valid === 1'b1) begin
      checks++;
      if (coin_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_coin cyc=%0d got=%0d expected=none", cyc, coin);
      end else begin
        ce = coin_q.pop_front();
        if (coin !== ce.val || cyc != ce.cy) begin
          failures++;
          $display("FAIL coin got=%0d@%0d expected=%0d@%0d", coin, cyc, ce.val, ce.cy);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done cyc=%0d", cyc);
      end else begin
        de = done_q.pop_front();
        if (cyc != de.cy || exact_amount !== de.ex || not_enough_change !== de.nec ||
            cough_up_more !== de.cum || remaining !== de.rem || pent_left !== de.p ||
            tri_left !== de.t || circ_left !== de.c) begin
          failures++;
          $display("FAIL done got cyc=%0d ex/nec/cum=%b%b%b rem=%0d inv=%0d/%0d/%0d expected cyc=%0d ex/nec/cum=%b%b%b rem=%0d inv=%0d/%0d/%0d",
                   cyc, exact_amount, not_enough_change, cough_up_more, remaining,
                   pent_left, tri_left, circ_left, de.cy, de.ex, de.nec, de.cum, de.rem,
                   de.p, de.t, de.c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_coin(input int cy, input logic [3:0] v);
    coin_q.push_back('{cy: cy, val: v});
  endtask

  task automatic push_done(input int cy, input logic ex, input logic nec, input logic cum,
                           input logic [3:0] rem, input logic [1:0] p, input logic [1:0] t,
                           input logic [1:0] c);
    done_q.push_back('{cy: cy, ex: ex, nec: nec, cum: cum, rem: rem, p: p, t: t, c: c});
  endtask

  task automatic txn(input logic [3:0] p, input logic [3:0] c);
    paid  = p;
    cost  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_restock(input logic [1:0] p, input logic [1:0] t, input logic [1:0] c);
    restock_pent = p;
    restock_tri  = t;
    restock_circ = c;
    restock      = 1'b1;
    tick();
    restock      = 1'b0;
  endtask

  task automatic drained(input string name);
    chk({name, "_coin_q"}, coin_q.size(), 0);
    chk({name, "_done_q"}, done_q.size(), 0);
  endtask

  int t;

  initial begin
    reset = 1'b1; start = 1'b0; restock = 1'b0;
    paid = '0; cost = '0; restock_pent = '0; restock_tri = '0; restock_circ = '0;
    idle(2);
    reset = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_coin", coin, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_flags", {exact_amount, not_enough_change, cough_up_more}, 0);
    chk("rst_inv", {pent_left, tri_left, circ_left}, {2'd3, 2'd3, 2'd3});

    // exact payment
    t = cyc;
    push_done(t + 1, 1, 0, 0, 4'd0, 2'd3, 2'd3, 2'd3);
    txn(4'd7, 4'd7);
    idle(3);
    chk("exact_held", exact_amount, 1);
    drained("exact");

    // underpayment
    t = cyc;
    push_done(t + 1, 0, 0, 1, 4'd0, 2'd3, 2'd3, 2'd3);
    txn(4'd2, 4'd6);
    idle(3);
    chk("cough_held", cough_up_more, 1);
    chk("cough_clears_exact", exact_amount, 0);
    drained("less");

    // change 8 -> 5 + 3
    t = cyc;
    push_coin(t + 1, 4'd5);
    push_coin(t + 2, 4'd3);
    push_done(t + 3, 0, 0, 0, 4'd0, 2'd2, 2'd2, 2'd3);
    txn(4'd10, 4'd2);
    idle(4);
    drained("change8");

    // change 7 from 1/1/1 -> 5 + 1, hits MAX_COINS with 1 still owed
    do_restock(2'd1, 2'd1, 2'd1);
    chk("restock_inv", {pent_left, tri_left, circ_left}, {2'd1, 2'd1, 2'd1});
    t = cyc;
    push_coin(t + 1, 4'd5);
    push_coin(t + 2, 4'd1);
    push_done(t + 3, 0, 1, 0, 4'd1, 2'd0, 2'd1, 2'd0);
    txn(4'd9, 4'd2);
    idle(4);
    drained("change7");

    // empty inventory: no coin, start pulses during GIVE and DONE ignored
    do_restock(2'd0, 2'd0, 2'd0);
    t = cyc;
    push_done(t + 2, 0, 1, 0, 4'd3, 2'd0, 2'd0, 2'd0);
    txn(4'd4, 4'd1);
    chk("give_busy", busy, 1);
    paid  = 4'd15;
    cost  = 4'd0;
    start = 1'b1;
    idle(2);
    start = 1'b0;
    chk("ignored_start_busy", busy, 0);
    chk("ignored_start_rem", remaining, 3);
    idle(2);
    drained("empty");

    // reset during GIVE after the first coin
    do_restock(2'd3, 2'd3, 2'd3);
    t = cyc;
    push_coin(t + 1, 4'd5);
    push_coin(t + 2, 4'd3);
    txn(4'd10, 4'd2);
    tick();
    chk("deducted_before_reset", pent_left, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_remaining", remaining, 0);
    chk("abort_inv", {pent_left, tri_left, circ_left}, {2'd3, 2'd3, 2'd3});
    idle(3);
    drained("abort");

    // restock and start together: restock wins
    restock_pent = 2'd2;
    restock_tri  = 2'd1;
    restock_circ = 2'd0;
    restock      = 1'b1;
    paid         = 4'd7;
    cost         = 4'd7;
    start        = 1'b1;
    tick();
    restock = 1'b0;
    start   = 1'b0;
    chk("rs_start_busy", busy, 0);
    chk("rs_start_inv", {pent_left, tri_left, circ_left}, {2'd2, 2'd1, 2'd0});
    idle(3);
    chk("rs_start_exact", exact_amount, 0);
    drained("rs_start");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sequential, parametrised change-making engine for the vending datapath.
- Holds an on-chip inventory of three coin types (pentagon, triangle, circle), all with parameterised values.
- Accepts a paid/cost transaction, then dispenses change greedily, one coin per clock, up to MAX_COINS coins, decrementing inventory as it goes.
- Reports exact / not-enough-change / cough-up-more status with a done pulse.
- Inventory is reloaded through a restock port between transactions.

Parameters:
- VALUE_W, 4: width of paid, cost, remaining and coin value.
- COUNT_W, 2: width of each per-type inventory counter.
- MAX_COINS, 2: maximum coins dispensed per transaction (>=1).
- PENT_VAL, 5: value of a pentagon.
- TRI_VAL, 3: value of a triangle.
- CIRC_VAL, 1: value of a circle. Values satisfy PENT_VAL > TRI_VAL > CIRC_VAL >= 1.
- INIT_CNT, 3: inventory of each type after reset (< 2**COUNT_W).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin transaction; accepted only in IDLE.
- paid  in  VALUE_W  amount inserted; sampled with start.
- cost  in  VALUE_W  item price; sampled with start.
- restock  in  1  load inventory; accepted only in IDLE.
- restock_pent / restock_tri / restock_circ  in  COUNT_W each  new counts; sampled with restock.
- busy  out  1  high in any non-IDLE state.
- coin_valid  out  1  a coin is dispensed this cycle.
- coin  out  VALUE_W  value of the dispensed coin; 0 when coin_valid=0.
- done  out  1  one-cycle pulse at transaction end.
- exact_amount / not_enough_change / cough_up_more  out  1 each  status; registered, held from DONE until the next accepted start.
- remaining  out  VALUE_W  change still owed; registered.
- pent_left / tri_left / circ_left  out  COUNT_W each  current inventory.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - Inventory = INIT_CNT each.
  - remaining=0, all status flags 0, coin count 0, done=0, coin_valid=0, coin=0.
  - Reset mid-transaction aborts it: no done pulse, and coins already dispensed stay deducted until the reset edge restores INIT_CNT.
- States: IDLE, GIVE, DONE.
- IDLE:
  - restock=1: load all three counters next edge; start in the same cycle is ignored (restock wins).
  - else start=1:
    - Clear all flags and coin count.
    - paid<cost: cough_up_more=1, remaining=0, go DONE.
    - paid==cost: exact_amount=1, remaining=0, go DONE.
    - else remaining=paid-cost (VALUE_W bits, no wrap because paid>cost), go GIVE.
- GIVE: each cycle the greedy pick chooses the largest value type with value<=remaining and count>0.
  - Priority is pentagon, then triangle, then circle.
  - If a coin is picked (combinational output this cycle):
    - coin_valid=1, coin=value.
    - Next edge: decrement that counter, remaining-=value, count+=1.
    - Go DONE if the new remaining==0 or count+1==MAX_COINS; not_enough_change=1 iff the new remaining!=0.
  - If no coin is eligible: coin_valid=0, not_enough_change=1, go DONE; remaining is unchanged.
- DONE: done=1 for exactly one cycle, then IDLE. start and restock are ignored in DONE.
- start or restock while busy: ignored, no effect.
- Counters never underflow, because a pick requires count>0. Restock values are taken verbatim.
- Latency:
  - Exact / less: start at cycle t gives done at t+1.
  - Change: coins at t+1..t+k, done at t+k+1 (k<=MAX_COINS).
  - No eligible coin: the GIVE cycle at t+1 has no coin, done at t+2.
- Dispensed coins are never refunded to inventory on not_enough_change.

Decomposition:
- Package change_pkg holds:
  - typedef enum state_t {IDLE, GIVE, DONE};
  - typedef enum coin_t {NONE, CIRC, TRI, PENT};
  - default value constants.
- Sub-module coin_picker (combinational):
  - Inputs: remaining, three counts, values.
  - Outputs: coin_t choice, chosen value, valid.
  - The FSM/inventory lives in change_dispenser.

Test Plan:
- Reset, then paid=7, cost=7, start -> next cycle done=1, exact_amount=1, no coin_valid, inventory 3/3/3.
- paid=2, cost=6 -> done at t+1, cough_up_more=1, remaining=0, inventory unchanged.
- Inventory 3/3/3, paid=10, cost=2 (change 8) -> t+1 coin=5, t+2 coin=3, done t+3, remaining=0, inventory 2/2/3.
- Restock 1/1/1, paid=9, cost=2 (change 7) -> coins 5 then 1, done t+3, not_enough_change=1, remaining=1, inventory 0/1/0.
- Restock 0/0/0, paid=4, cost=1 -> t+1 no coin, done t+2, not_enough_change=1, remaining=3; start pulsed during GIVE is ignored.
- Assert reset during GIVE after the first coin -> next cycle IDLE, busy=0, no done, inventory 3/3/3; restock+start together in IDLE -> inventory loaded, start ignored.
